// File: rtl/jerky_counter_gen_if.sv
// Bus bundle for jerky_counter_gen: control inputs, load value and registered outputs.
// The driver (bench or upstream walker) takes the master view; the counter takes the slave view.
interface jerky_counter_gen_if #(
   parameter int WIDTH = 5
);
   logic             enable;
   logic             mode;
   logic             dir;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] count;
   logic             class_wrap;
   logic             seq_wrap;

   modport master (
      output enable, mode, dir, load, load_val,
      input  count, class_wrap, seq_wrap
   );

   modport slave (
      input  enable, mode, dir, load, load_val,
      output count, class_wrap, seq_wrap
   );
endinterface

// File: rtl/jerky_counter_gen.sv
// jerky_counter_gen: WIDTH-bit counter with linear or interleaved ("jerky") order,
// up/down direction, synchronous load and registered wrap pulses.
// Jerky order walks residue class 0 (mod 2**STRIDE_LOG2) ascending, then class 1, ...
// Optional macro JERKY_COUNTER_GEN_PROBE_EN adds probe_k / probe_c field outputs.
module jerky_counter_gen #(
   parameter int WIDTH       = 5,
   parameter int STRIDE_LOG2 = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   jerky_counter_gen_if.slave    bus
`ifdef JERKY_COUNTER_GEN_PROBE_EN
   ,
   output logic [WIDTH-STRIDE_LOG2-1:0]                  probe_k,
   output logic [((STRIDE_LOG2 > 0) ? STRIDE_LOG2 : 1)-1:0] probe_c
`endif
);

   // CMASK covers the class field; STEP is one increment of the step-index field.
   localparam logic [WIDTH-1:0] ONES  = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] CMASK = WIDTH'((1 << STRIDE_LOG2) - 1);
   localparam logic [WIDTH-1:0] STEP  = WIDTH'(1 << STRIDE_LOG2);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] adv_count;
   logic             adv_cw;
   logic             adv_sw;
   logic             class_wrap_q;
   logic             seq_wrap_q;

   logic k_is_max;
   logic k_is_zero;

   // k field all ones <=> count with class bits forced high is all ones.
   assign k_is_max  = ((count_q | CMASK) == ONES);
   assign k_is_zero = ((count_q & ~CMASK) == '0);

   // Next value and wrap flags if the counter advances this cycle.
   always_comb begin
      adv_count = count_q;
      adv_cw    = 1'b0;
      adv_sw    = 1'b0;
      if (!bus.mode) begin
         if (!bus.dir) begin
            adv_count = count_q + 1'b1;
            adv_sw    = (count_q == ONES);
         end else begin
            adv_count = count_q - 1'b1;
            adv_sw    = (count_q == '0);
         end
      end else if (!bus.dir) begin
         if (!k_is_max) begin
            adv_count = count_q + STEP;
         end else begin
            // k -> 0, c -> c+1 mod STRIDE; with k=KMAX, c=CMAX means count is all ones.
            adv_count = (count_q + 1'b1) & CMASK;
            adv_cw    = 1'b1;
            adv_sw    = (count_q == ONES);
         end
      end else begin
         if (!k_is_zero) begin
            adv_count = count_q - STEP;
         end else begin
            // k -> KMAX, c -> c-1 mod STRIDE; with k=0, c=0 means count is zero.
            adv_count = ~CMASK | ((count_q - 1'b1) & CMASK);
            adv_cw    = 1'b1;
            adv_sw    = (count_q == '0);
         end
      end
   end

   // State register: reset > load > enable; flags are single-cycle pulses.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_q      <= '0;
         class_wrap_q <= 1'b0;
         seq_wrap_q   <= 1'b0;
      end else if (bus.load) begin
         count_q      <= bus.load_val;
         class_wrap_q <= 1'b0;
         seq_wrap_q   <= 1'b0;
      end else if (bus.enable) begin
         count_q      <= adv_count;
         class_wrap_q <= adv_cw;
         seq_wrap_q   <= adv_sw;
      end else begin
         class_wrap_q <= 1'b0;
         seq_wrap_q   <= 1'b0;
      end
   end

   assign bus.count      = count_q;
   assign bus.class_wrap = class_wrap_q;
   assign bus.seq_wrap   = seq_wrap_q;

`ifdef JERKY_COUNTER_GEN_PROBE_EN
   assign probe_k = count_q[WIDTH-1:STRIDE_LOG2];
   if (STRIDE_LOG2 > 0) begin : g_probe_c
      assign probe_c = count_q[((STRIDE_LOG2 > 0) ? STRIDE_LOG2 : 1)-1:0];
   end else begin : g_probe_c0
      assign probe_c = '0;
   end
`endif

endmodule

// File: tb/tb_jerky_counter_gen.sv
// Bench for jerky_counter_gen: three instances (5/1, 6/2, 4/0) share one stimulus stream.
// A position-in-sequence model predicts every output each cycle; directed literals pin it.
module tb_jerky_counter_gen;

   logic clk;
   logic reset;
   logic enable, mode, dir, load;
   logic [5:0] lv;

   int tests = 0;
   int fails = 0;

   jerky_counter_gen_if #(.WIDTH(5)) b5 ();
   jerky_counter_gen_if #(.WIDTH(6)) b6 ();
   jerky_counter_gen_if #(.WIDTH(4)) b4 ();

   assign b5.enable = enable; assign b5.mode = mode; assign b5.dir = dir;
   assign b5.load = load;     assign b5.load_val = lv[4:0];
   assign b6.enable = enable; assign b6.mode = mode; assign b6.dir = dir;
   assign b6.load = load;     assign b6.load_val = lv;
   assign b4.enable = enable; assign b4.mode = mode; assign b4.dir = dir;
   assign b4.load = load;     assign b4.load_val = lv[3:0];

`ifdef JERKY_COUNTER_GEN_PROBE_EN
   logic [3:0] pk5; logic [0:0] pc5;
   logic [3:0] pk6; logic [1:0] pc6;
   logic [3:0] pk4; logic [0:0] pc4;
   jerky_counter_gen #(.WIDTH(5), .STRIDE_LOG2(1)) u5 (.clk(clk), .reset(reset), .bus(b5.slave), .probe_k(pk5), .probe_c(pc5));
   jerky_counter_gen #(.WIDTH(6), .STRIDE_LOG2(2)) u6 (.clk(clk), .reset(reset), .bus(b6.slave), .probe_k(pk6), .probe_c(pc6));
   jerky_counter_gen #(.WIDTH(4), .STRIDE_LOG2(0)) u4 (.clk(clk), .reset(reset), .bus(b4.slave), .probe_k(pk4), .probe_c(pc4));
`else
   jerky_counter_gen #(.WIDTH(5), .STRIDE_LOG2(1)) u5 (.clk(clk), .reset(reset), .bus(b5.slave));
   jerky_counter_gen #(.WIDTH(6), .STRIDE_LOG2(2)) u6 (.clk(clk), .reset(reset), .bus(b6.slave));
   jerky_counter_gen #(.WIDTH(4), .STRIDE_LOG2(0)) u4 (.clk(clk), .reset(reset), .bus(b4.slave));
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input int got, input int exp);
      tests++;
      if (got != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", nm, got, exp);
      end
   endtask

   // Sequence model: a jerky value v sits at position pos = c*KN + k of the period;
   // stepping moves pos by +-1 mod N. Linear mode is plain modular arithmetic.
   function automatic void model_step(input int w, input int sl, input int v,
                                      input int md, input int dr,
                                      output int nv, output int cw, output int sw);
      int n, kn, stride, pos, np;
      n = 1 << w; stride = 1 << sl; kn = n / stride;
      if (md == 0) begin
         nv = dr ? (v + n - 1) % n : (v + 1) % n;
         sw = dr ? int'(v == 0) : int'(v == n - 1);
         cw = 0;
      end else begin
         pos = (v % stride) * kn + v / stride;
         np  = dr ? (pos + n - 1) % n : (pos + 1) % n;
         nv  = (np % kn) * stride + np / kn;
         cw  = dr ? int'(pos % kn == 0) : int'((pos + 1) % kn == 0);
         sw  = dr ? int'(pos == 0) : int'(pos == n - 1);
      end
   endfunction

   int mw[3] = '{5, 6, 4};
   int ms[3] = '{1, 2, 0};
   int mc[3], mcw[3], msw[3];
   bit mvalid = 0;

   // Model advance on each rising edge from the inputs the DUTs see.
   always @(posedge clk) begin
      for (int d = 0; d < 3; d++) begin
         int nv, cw, sw;
         if (reset) begin
            mc[d] = 0; mcw[d] = 0; msw[d] = 0;
         end else if (load) begin
            mc[d] = int'(lv) % (1 << mw[d]); mcw[d] = 0; msw[d] = 0;
         end else if (enable) begin
            model_step(mw[d], ms[d], mc[d], int'(mode), int'(dir), nv, cw, sw);
            mc[d] = nv; mcw[d] = cw; msw[d] = sw;
         end else begin
            mcw[d] = 0; msw[d] = 0;
         end
      end
      if (reset) mvalid = 1;
   end

   // Per-cycle comparison of all three instances against the model.
   always @(negedge clk) begin
      if (mvalid) begin
         chk("m5.count", int'(b5.count), mc[0]);
         chk("m5.class_wrap", int'(b5.class_wrap), mcw[0]);
         chk("m5.seq_wrap", int'(b5.seq_wrap), msw[0]);
         chk("m6.count", int'(b6.count), mc[1]);
         chk("m6.class_wrap", int'(b6.class_wrap), mcw[1]);
         chk("m6.seq_wrap", int'(b6.seq_wrap), msw[1]);
         chk("m4.count", int'(b4.count), mc[2]);
         chk("m4.class_wrap", int'(b4.class_wrap), mcw[2]);
         chk("m4.seq_wrap", int'(b4.seq_wrap), msw[2]);
`ifdef JERKY_COUNTER_GEN_PROBE_EN
         chk("p5.k", int'(pk5), mc[0] >> 1);
         chk("p5.c", int'(pc5), mc[0] % 2);
         chk("p6.k", int'(pk6), mc[1] >> 2);
         chk("p6.c", int'(pc6), mc[1] % 4);
         chk("p4.k", int'(pk4), mc[2]);
         chk("p4.c", int'(pc4), 0);
`endif
      end
   end

   // Mixed mode/dir/enable segments: {mode, dir, enable}
   logic [2:0] mix [8] = '{3'b110, 3'b111, 3'b011, 3'b100, 3'b101, 3'b001, 3'b111, 3'b010};

   initial begin
      int cw_n, sw_n;
      reset = 1; enable = 1; mode = 1; dir = 0; load = 0; lv = '0;

      // 1. reset with enable high
      repeat (2) @(negedge clk);
      chk("rst.count", int'(b5.count), 0);
      chk("rst.class_wrap", int'(b5.class_wrap), 0);
      chk("rst.seq_wrap", int'(b5.seq_wrap), 0);

      // 2. jerky up, one full period
      reset = 0; cw_n = 0; sw_n = 0;
      for (int i = 1; i <= 32; i++) begin
         @(negedge clk);
         cw_n += int'(b5.class_wrap); sw_n += int'(b5.seq_wrap);
         if (i == 1)  chk("up.first", int'(b5.count), 2);
         if (i == 15) chk("up.c0_end", int'(b5.count), 30);
         if (i == 16) begin
            chk("up.c1_start", int'(b5.count), 1);
            chk("up.cw_30_1", int'(b5.class_wrap), 1);
            chk("up.sw_30_1", int'(b5.seq_wrap), 0);
         end
         if (i == 32) begin
            chk("up.wrap0", int'(b5.count), 0);
            chk("up.sw_31_0", int'(b5.seq_wrap), 1);
         end
      end
      chk("up.cw_total", cw_n, 2);
      chk("up.sw_total", sw_n, 1);

      // 3. jerky down, one full period
      dir = 1; cw_n = 0; sw_n = 0;
      for (int i = 1; i <= 32; i++) begin
         @(negedge clk);
         cw_n += int'(b5.class_wrap); sw_n += int'(b5.seq_wrap);
         if (i == 1) begin
            chk("dn.first", int'(b5.count), 31);
            chk("dn.cw_0_31", int'(b5.class_wrap), 1);
            chk("dn.sw_0_31", int'(b5.seq_wrap), 1);
         end
         if (i == 16) chk("dn.c1_end", int'(b5.count), 1);
         if (i == 17) begin
            chk("dn.c0_start", int'(b5.count), 30);
            chk("dn.sw_1_30", int'(b5.seq_wrap), 0);
         end
      end
      chk("dn.cw_total", cw_n, 2);
      chk("dn.sw_total", sw_n, 1);
      chk("dn.back0", int'(b5.count), 0);

      // 4. load beats enable, then hold
      dir = 0;
      repeat (3) @(negedge clk);
      chk("ld.pre", int'(b5.count), 6);
      load = 1; lv = 6'd17;
      @(negedge clk);
      chk("ld.count", int'(b5.count), 17);
      chk("ld.cw", int'(b5.class_wrap), 0);
      chk("ld.sw", int'(b5.seq_wrap), 0);
      load = 0;
      @(negedge clk);
      chk("ld.next", int'(b5.count), 19);
      enable = 0;
      repeat (3) begin
         @(negedge clk);
         chk("hold", int'(b5.count), 19);
      end

      // 5. linear wrap, then switch to jerky mid-run
      enable = 1; load = 1; lv = 6'd30;
      @(negedge clk);
      load = 0; mode = 0; dir = 0;
      @(negedge clk); chk("lin.31", int'(b5.count), 31);
      @(negedge clk);
      chk("lin.0", int'(b5.count), 0);
      chk("lin.sw", int'(b5.seq_wrap), 1);
      chk("lin.cw", int'(b5.class_wrap), 0);
      @(negedge clk); chk("lin.1", int'(b5.count), 1);
      mode = 1;
      @(negedge clk); chk("sw_mode.3", int'(b5.count), 3);

      // mixed segments, checked by the model
      for (int s = 0; s < 8; s++) begin
         mode = mix[s][2]; dir = mix[s][1]; enable = mix[s][0];
         repeat (5) @(negedge clk);
      end

      // 6. WIDTH=6 / STRIDE_LOG2=2 full period, then reset mid-run
      reset = 1;
      @(negedge clk);
      reset = 0; mode = 1; dir = 0; enable = 1; cw_n = 0; sw_n = 0;
      for (int i = 1; i <= 64; i++) begin
         @(negedge clk);
         if (b6.class_wrap && !b6.seq_wrap) cw_n++;
         sw_n += int'(b6.seq_wrap);
         if (i == 15) chk("w6.60", int'(b6.count), 60);
         if (i == 16) chk("w6.1", int'(b6.count), 1);
         if (i == 16) begin
            chk("w4.wrap0", int'(b4.count), 0);
            chk("w4.cw_mirror", int'(b4.class_wrap), 1);
            chk("w4.sw", int'(b4.seq_wrap), 1);
         end
      end
      chk("w6.cw_only", cw_n, 3);
      chk("w6.sw_total", sw_n, 1);
      chk("w6.back0", int'(b6.count), 0);
      repeat (19) @(negedge clk);
      chk("w6.13", int'(b6.count), 13);
      reset = 1;
      @(negedge clk);
      chk("w6.rst", int'(b6.count), 0);
      chk("w5.rst", int'(b5.count), 0);
      reset = 0;
      repeat (3) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
